// File: rtl/dma_xfer_seq.sv
// dma_xfer_seq: single-channel read-then-write DMA sequencer.
// Optional auto-repeat with trigger wait: define DMA_XFER_REPEAT_EN.
module dma_xfer_seq #(
  parameter int AW = 28,
  parameter int CW = 14
) (
  input  logic          clk,
  input  logic          rst_b,
  input  logic          start,
  input  logic          abort,
  input  logic [AW-1:0] src_in,
  input  logic [AW-1:0] dst_in,
  input  logic [CW-1:0] cnt_in,
  input  logic [1:0]    src_mode,
  input  logic [1:0]    dst_mode,
  input  logic          word32,
`ifdef DMA_XFER_REPEAT_EN
  input  logic          repeat_in,
  input  logic          trig,
`endif
  output logic          bus_req,
  output logic          bus_rd,
  output logic [AW-1:0] bus_addr,
  input  logic          bus_ack,
  input  logic [31:0]   bus_rdata,
  output logic [31:0]   bus_wdata,
  output logic          busy,
  output logic          done
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    READ      = 3'd1,
    WRITE     = 3'd2,
`ifdef DMA_XFER_REPEAT_EN
    WAIT_TRIG = 3'd4,
`endif
    DONE      = 3'd3
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] src_q, src_d;
  logic [AW-1:0] dst_q, dst_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [1:0]    smode_q, smode_d;
  logic [1:0]    dmode_q, dmode_d;
  logic          w32_q, w32_d;
`ifdef DMA_XFER_REPEAT_EN
  logic          rep_q, rep_d;
`endif

  // Next address: 01 steps down, 10 holds, 00/11 step up; wraps mod 2^AW.
  function automatic logic [AW-1:0] step_addr(
    input logic [AW-1:0] a,
    input logic [1:0]    m,
    input logic          w
  );
    logic [AW-1:0] s;
    s = w ? AW'(4) : AW'(2);
    unique case (m)
      2'b01:   step_addr = a - s;
      2'b10:   step_addr = a;
      default: step_addr = a + s;
    endcase
  endfunction

  // Next-state and datapath updates; abort overrides everything.
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    cnt_d   = cnt_q;
    wdata_d = wdata_q;
    smode_d = smode_q;
    dmode_d = dmode_q;
    w32_d   = w32_q;
`ifdef DMA_XFER_REPEAT_EN
    rep_d   = rep_q;
`endif
    if (abort) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: if (start) begin
          src_d   = src_in;
          dst_d   = dst_in;
          cnt_d   = cnt_in;
          smode_d = src_mode;
          dmode_d = dst_mode;
          w32_d   = word32;
`ifdef DMA_XFER_REPEAT_EN
          rep_d   = repeat_in;
`endif
          state_d = READ;
        end
        READ: if (bus_ack) begin
          wdata_d = bus_rdata;
          state_d = WRITE;
        end
        WRITE: if (bus_ack) begin
          cnt_d   = cnt_q - CW'(1);
          src_d   = step_addr(src_q, smode_q, w32_q);
          dst_d   = step_addr(dst_q, dmode_q, w32_q);
          state_d = (cnt_q == CW'(1)) ? DONE : READ;
        end
        DONE: begin
          state_d = IDLE;
`ifdef DMA_XFER_REPEAT_EN
          if (rep_q) begin
            cnt_d = cnt_in;
            if (dmode_q == 2'b11) dst_d = dst_in;
            state_d = WAIT_TRIG;
          end
`endif
        end
`ifdef DMA_XFER_REPEAT_EN
        WAIT_TRIG: if (trig) state_d = READ;
`endif
        default: state_d = IDLE;
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      cnt_q   <= '0;
      wdata_q <= '0;
      smode_q <= '0;
      dmode_q <= '0;
      w32_q   <= 1'b0;
`ifdef DMA_XFER_REPEAT_EN
      rep_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      cnt_q   <= cnt_d;
      wdata_q <= wdata_d;
      smode_q <= smode_d;
      dmode_q <= dmode_d;
      w32_q   <= w32_d;
`ifdef DMA_XFER_REPEAT_EN
      rep_q   <= rep_d;
`endif
    end
  end

  assign bus_req   = (state_q == READ) || (state_q == WRITE);
  assign bus_rd    = (state_q == READ);
  assign bus_addr  = (state_q == READ)  ? src_q :
                     (state_q == WRITE) ? dst_q : '0;
  assign bus_wdata = wdata_q;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);

endmodule

// File: tb/tb_dma_xfer_seq.sv
// tb_dma_xfer_seq: vector table, corner sequences and randomized
// transfers checked against an address-arithmetic reference model.
module tb_dma_xfer_seq;
  localparam int AW = 28;
  localparam int CW = 14;

  logic          clk = 1'b0;
  logic          rst_b = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [AW-1:0] src_in = '0;
  logic [AW-1:0] dst_in = '0;
  logic [CW-1:0] cnt_in = '0;
  logic [1:0]    src_mode = '0;
  logic [1:0]    dst_mode = '0;
  logic          word32 = 1'b0;
`ifdef DMA_XFER_REPEAT_EN
  logic          repeat_in = 1'b0;
  logic          trig = 1'b0;
`endif
  logic          bus_req;
  logic          bus_rd;
  logic [AW-1:0] bus_addr;
  logic          bus_ack = 1'b0;
  logic [31:0]   bus_rdata = '0;
  logic [31:0]   bus_wdata;
  logic          busy;
  logic          done;

  int n_cmp = 0;
  int n_fail = 0;

  dma_xfer_seq #(.AW(AW), .CW(CW)) dut (
    .clk(clk), .rst_b(rst_b), .start(start), .abort(abort),
    .src_in(src_in), .dst_in(dst_in), .cnt_in(cnt_in),
    .src_mode(src_mode), .dst_mode(dst_mode), .word32(word32),
`ifdef DMA_XFER_REPEAT_EN
    .repeat_in(repeat_in), .trig(trig),
`endif
    .bus_req(bus_req), .bus_rd(bus_rd), .bus_addr(bus_addr),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata), .bus_wdata(bus_wdata),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Bus slave: 0 random latency, 1 always ack, 2 never, 3 reads only.
  int          ack_mode = 0;
  bit          acc_rd[$];
  logic [AW-1:0] acc_addr[$];
  logic [31:0] acc_data[$];
  bit          prev_pend = 0;
  bit          prev_rd = 0;
  logic [AW-1:0] prev_addr = '0;

  always @(negedge clk) begin
    bit a;
    if (!rst_b) begin
      bus_ack = 1'b0;
      prev_pend = 0;
    end else begin
      if (prev_pend && bus_req)
        chk("hold", {3'b0, bus_rd, bus_addr}, {3'b0, prev_rd, prev_addr});
      bus_rdata = $urandom;
      case (ack_mode)
        0: a = 1'($urandom_range(0, 1));
        1: a = 1;
        2: a = 0;
        default: a = bus_rd;
      endcase
      bus_ack = a;
      if (a && bus_req) begin
        acc_rd.push_back(bus_rd);
        acc_addr.push_back(bus_addr);
        acc_data.push_back(bus_rd ? bus_rdata : bus_wdata);
      end
      prev_pend = bus_req && !a;
      prev_rd = bus_rd;
      prev_addr = bus_addr;
    end
  end

  // Address of the k-th unit from the transfer rules.
  function automatic logic [AW-1:0] mdl(input logic [AW-1:0] b,
    input logic [1:0] m, input bit w, input int k);
    longint st;
    longint v;
    st = w ? 4 : 2;
    case (m)
      2'b01: v = longint'(b) - st * k;
      2'b10: v = longint'(b);
      default: v = longint'(b) + st * k;
    endcase
    return v[AW-1:0];
  endfunction

  task automatic clear_log();
    acc_rd.delete();
    acc_addr.delete();
    acc_data.delete();
  endtask

  task automatic check_seq(input string nm, input logic [AW-1:0] s,
    input logic [AW-1:0] d, input logic [CW-1:0] c,
    input logic [1:0] sm, input logic [1:0] dm, input bit w);
    int n;
    int bad;
    n = (c == 0) ? (1 << CW) : int'(c);
    bad = -1;
    chk({nm, "_len"}, acc_addr.size(), 2 * n);
    if (acc_addr.size() == 2 * n) begin
      for (int k = 0; k < n && bad < 0; k++) begin
        if (acc_rd[2*k] !== 1'b1 || acc_addr[2*k] !== mdl(s, sm, w, k))
          bad = 2 * k;
        else if (acc_rd[2*k+1] !== 1'b0 ||
                 acc_addr[2*k+1] !== mdl(d, dm, w, k) ||
                 acc_data[2*k+1] !== acc_data[2*k])
          bad = 2 * k + 1;
      end
      n_cmp++;
      if (bad >= 0) begin
        n_fail++;
        $display("FAIL %s_seq: entry %0d rd=%0b addr=%h data=%h", nm,
                 bad, acc_rd[bad], acc_addr[bad], acc_data[bad]);
      end
    end
  endtask

  task automatic run(input string nm, input logic [AW-1:0] s,
    input logic [AW-1:0] d, input logic [CW-1:0] c,
    input logic [1:0] sm, input logic [1:0] dm, input bit w,
    input bit poke, input int lim);
    bit got;
    clear_log();
    @(negedge clk);
    src_in = s; dst_in = d; cnt_in = c;
    src_mode = sm; dst_mode = dm; word32 = w;
    start = 1;
    @(negedge clk);
    start = 0;
    chk({nm, "_req1"}, bus_req, 1);
    got = 0;
    for (int i = 0; i < lim && !got; i++) begin
      @(negedge clk);
      if (i == 0 && poke && busy) begin
        start = 1; src_in = ~s; dst_in = ~d; cnt_in = c + 3;
      end else begin
        start = 0;
      end
      if (done) got = 1;
    end
    start = 0;
    n_cmp++;
    if (!got) begin
      n_fail++;
      $display("FAIL %s_done: got none want pulse in %0d cycles", nm, lim);
    end else begin
      @(negedge clk);
      chk({nm, "_pulse"}, done, 0);
      chk({nm, "_idle"}, busy, 0);
    end
    check_seq(nm, s, d, c, sm, dm, w);
  endtask

  typedef struct {
    logic [AW-1:0] s, d;
    logic [CW-1:0] c;
    logic [1:0]    sm, dm;
    bit            w;
    int            n;
    logic [AW-1:0] lr, lw;
  } vec_t;

  vec_t tbl[6];
  bit   got;
  int   nw;
  int   lr_i;
  int   lw_i;

  initial begin
    tbl[0] = '{28'h100, 28'h200, 3, 2'b00, 2'b00, 1, 3, 28'h108, 28'h208};
    tbl[1] = '{28'h0, 28'h40, 2, 2'b01, 2'b10, 0, 2, 28'hFFFFFFE, 28'h40};
    tbl[2] = '{28'hFFFFFFC, 28'h10, 2, 2'b00, 2'b11, 1, 2, 28'h0, 28'h14};
    tbl[3] = '{28'h20, 28'h8, 3, 2'b11, 2'b01, 1, 3, 28'h28, 28'h0};
    tbl[4] = '{28'h55, 28'h0, 1, 2'b10, 2'b01, 0, 1, 28'h55, 28'h0};
    tbl[5] = '{28'h1000, 28'h2, 4, 2'b10, 2'b01, 0, 4, 28'h1000,
               28'hFFFFFFC};

    repeat (2) @(negedge clk);
    chk("rst_req", bus_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_addr", bus_addr, 0);
    chk("rst_wdata", bus_wdata, 0);
    chk("rst_done", done, 0);
    rst_b = 1;

    ack_mode = 0;
    foreach (tbl[i]) begin
      run($sformatf("vec%0d", i), tbl[i].s, tbl[i].d, tbl[i].c,
          tbl[i].sm, tbl[i].dm, tbl[i].w, 0, 300);
      nw = 0; lr_i = -1; lw_i = -1;
      foreach (acc_rd[k]) begin
        if (acc_rd[k]) lr_i = k;
        else begin nw++; lw_i = k; end
      end
      chk($sformatf("vec%0d_nwr", i), nw, tbl[i].n);
      if (lr_i >= 0 && lw_i >= 0) begin
        chk($sformatf("vec%0d_lastrd", i), acc_addr[lr_i], tbl[i].lr);
        chk($sformatf("vec%0d_lastwr", i), acc_addr[lw_i], tbl[i].lw);
      end
    end

    // Abort in the second READ while the slave acks.
    clear_log();
    ack_mode = 1;
    @(negedge clk);
    src_in = 28'h100; dst_in = 28'h200; cnt_in = 3;
    src_mode = 0; dst_mode = 0; word32 = 1; start = 1;
    @(negedge clk); start = 0;
    @(negedge clk);
    @(negedge clk);
    chk("ab_rd2", {bus_req, bus_rd, bus_addr}, {2'b11, 28'h104});
    abort = 1;
    @(negedge clk); abort = 0;
    chk("ab_req", bus_req, 0);
    chk("ab_busy", busy, 0);
    got = 0;
    for (int i = 0; i < 4; i++) begin
      if (done) got = 1;
      @(negedge clk);
    end
    chk("ab_nodone", got, 0);

    // Abort beats start in IDLE.
    start = 1; abort = 1;
    @(negedge clk); start = 0; abort = 0;
    chk("ab_start", busy, 0);

    // Asynchronous reset in the middle of a write access.
    ack_mode = 3;
    @(negedge clk);
    src_in = 28'h700; dst_in = 28'h900; cnt_in = 2; start = 1;
    @(negedge clk); start = 0;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (bus_req && !bus_rd) got = 1;
      else @(negedge clk);
    end
    chk("rs_inwrite", got, 1);
    #2 rst_b = 0;
    #1;
    chk("rs_out", {bus_req, bus_rd, busy, done}, 0);
    chk("rs_addr", bus_addr, 0);
    chk("rs_wdata", bus_wdata, 0);
    @(negedge clk); rst_b = 1;
    ack_mode = 0;
    run("rs_again", 28'h300, 28'h400, 2, 2'b00, 2'b00, 1, 0, 200);

`ifdef DMA_XFER_REPEAT_EN
    ack_mode = 1;
    @(negedge clk);
    src_in = 28'h300; dst_in = 28'h500; cnt_in = 1;
    src_mode = 2'b00; dst_mode = 2'b11; word32 = 1;
    repeat_in = 1; start = 1;
    @(negedge clk); start = 0; repeat_in = 0;
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (done) got = 1;
    end
    chk("rep_done", got, 1);
    chk("rep_busy", busy, 1);
    @(negedge clk);
    chk("rep_wait", {busy, bus_req, done}, 3'b100);
    trig = 1;
    @(negedge clk); trig = 0;
    chk("rep_read", {bus_req, bus_rd, bus_addr}, {2'b11, 28'h304});
    @(negedge clk);
    chk("rep_dst", {bus_req, bus_rd, bus_addr}, {2'b10, 28'h500});
    abort = 1;
    @(negedge clk); abort = 0;
    chk("rep_abort", busy, 0);
    ack_mode = 0;
`endif

    for (int r = 0; r < 25; r++) begin
      run($sformatf("rnd%0d", r), AW'($urandom), AW'($urandom),
          CW'($urandom_range(1, 6)), 2'($urandom), 2'($urandom),
          1'($urandom), 1, 200);
    end

    // Count of zero means the full 2^CW units.
    ack_mode = 1;
    run("full", 28'h0, 28'h8000000 - 28'h4, 0, 2'b00, 2'b00, 1, 0,
        (1 << (CW + 1)) + 100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/dma_xfer_seq.md
DMA_XFER_SEQ -- requirements
Module: dma_xfer_seq

Interface
REQ-001 Parameter AW, default 28, SHALL set the address width.
REQ-002 Parameter CW, default 14, SHALL set the word-count width.
REQ-003 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_b  in  1  SHALL be the asynchronous, active-low reset.
REQ-005 start  in  1  SHALL request a transfer when high in IDLE.
REQ-006 abort  in  1  SHALL terminate any transfer.
REQ-007 src_in  in  AW  SHALL be the start source address, latched on accepted start.
REQ-008 dst_in  in  AW  SHALL be the start destination address, latched on accepted start.
REQ-009 cnt_in  in  CW  SHALL be the unit count; 0 SHALL mean 2^CW.
REQ-010 src_mode, dst_mode  in  2  SHALL select the step: 00 increment, 01 decrement, 10 fixed, 11 increment (11 reloads dst on repeat).
REQ-011 word32  in  1  SHALL set the step to 4 when high and 2 when low.
REQ-012 bus_req  out  1  SHALL request a bus access.
REQ-013 bus_rd  out  1  SHALL mark a read (1) or a write (0).
REQ-014 bus_addr  out  AW  SHALL be the access address.
REQ-015 bus_ack  in  1  SHALL complete the current access.
REQ-016 bus_rdata  in  32  SHALL be read data, valid with bus_ack.
REQ-017 bus_wdata  out  32  SHALL be latched write data.
REQ-018 busy  out  1  SHALL be high outside IDLE.
REQ-019 done  out  1  SHALL be a one-cycle completion pulse.

Function
REQ-020 States SHALL be IDLE, READ, WRITE, DONE, plus WAIT_TRIG when the REQ-032 repeat macro is defined.
REQ-021 IDLE with start=1 SHALL latch src/dst/cnt/modes/word32 and enter READ; the first bus_req SHALL assert the cycle after start.
REQ-022 READ SHALL drive bus_req=1, bus_rd=1 and bus_addr=src; on bus_ack it SHALL capture bus_rdata into bus_wdata and enter WRITE.
REQ-023 WRITE SHALL drive bus_req=1, bus_rd=0 and bus_addr=dst.
REQ-024 On WRITE bus_ack, remaining count SHALL decrement by 1 and src/dst SHALL step per mode.
REQ-025 After REQ-024, the sequencer SHALL enter DONE if the count was 1, else READ with no idle cycle.
REQ-026 Address arithmetic SHALL wrap modulo 2^AW; fixed mode SHALL hold the address.
REQ-027 DONE SHALL assert done for exactly one cycle, then go to IDLE.
REQ-028 bus_req SHALL stay high and bus_addr stable until bus_ack.
REQ-029 start while busy SHALL be ignored.
REQ-030 abort SHALL take priority over bus_ack and start: the next state SHALL be IDLE, bus_req SHALL drop next cycle, and done SHALL NOT pulse.

Reset
REQ-031 rst_b low SHALL force IDLE and clear all outputs, latched addresses, count and bus_wdata to 0 immediately, including mid-access.

Configuration
REQ-032 Macro DMA_XFER_REPEAT_EN, when defined, SHALL add inputs repeat_in (1) and trig (1); repeat_in SHALL be latched on accepted start.
REQ-033 With DMA_XFER_REPEAT_EN and repeat latched, DONE SHALL pulse done, reload the count from cnt_in, reload dst from dst_in if dst_mode=11, keep src, and enter WAIT_TRIG.
REQ-034 WAIT_TRIG SHALL keep busy=1 and enter READ the cycle after trig=1; abort SHALL exit to IDLE.
REQ-035 Without DMA_XFER_REPEAT_EN, repeat_in and trig SHALL be absent and DONE SHALL always go to IDLE.

Verification
REQ-036 src=0x100, dst=0x200, cnt=3, word32=1, inc/inc, ack after 1 cycle -> reads 0x100/0x104/0x108, writes 0x200/0x204/0x208, one done pulse.
REQ-037 cnt=2, word32=0, src dec from 0x0000000, dst fixed 0x40 -> reads 0x0000000 then 0xFFFFFFE, both writes to 0x40.
REQ-038 abort during the second READ with bus_ack high that cycle -> IDLE next cycle, bus_req=0, no done, busy=0.
REQ-039 rst_b low mid-WRITE -> all outputs 0 immediately; a start after release restarts cleanly.
REQ-040 cnt_in=0 with bus_ack held high -> exactly 2^CW write accesses before done.
REQ-041 DMA_XFER_REPEAT_EN, repeat=1, dst_mode=11, cnt=1 -> done pulse, busy held, dst back to dst_in, READ one cycle after trig.
